video_frame_buffer: RTL and testbench
=====================================

VIDEO_FRAME_BUFFER -- requirements
Module: video_frame_buffer

Interface
REQ-001 Parameters SHALL be: FRAME_W, default 160, pixels per line; FRAME_H, default 120, lines per frame; REPEAT, default 2, display refreshes per video frame.
REQ-002 Derived values SHALL be: FRAME_PIX = FRAME_W*FRAME_H; FRAME_BYTES = FRAME_PIX/8; FRAME_W multiple of 8.
REQ-003 Ports SHALL be, in order (name, direction, width, meaning):
- CLK_50, in, 1, sole clock.
- reset, in, 1, asynchronous active-high reset.
- SPI_clock_enable, in, 1, one-cycle strobe marking a valid MISO bit.
- MISO, in, 1, serial video data, MSB first.
- write_video, in, 1, write-window enable from the data FSM.
- video_bank_sel, in, 1, bank being written.
- video_bank_full, out, 1, level: current write bank holds FRAME_BYTES bytes.
- pix_en, in, 1, display requests next pixel this cycle.
- frame_sync, in, 1, one-cycle pulse at vertical blank start.
- pixel, out, 1, monochrome pixel, 1 = white.
- pixel_valid, out, 1, qualifies pixel.
- frame_done, out, 1, one-cycle pulse: displayed frame finished REPEAT refreshes.

Function
REQ-004 Write side SHALL shift MISO into an 8-bit register on each cycle with SPI_clock_enable=1 and write_video=1; first bit lands in bit 7.
REQ-005 On the 8th such bit, the assembled byte SHALL be written to RAM address {video_bank_sel, wr_addr}; wr_addr then increments.
REQ-006 When wr_addr reaches FRAME_BYTES, video_bank_full SHALL assert in the same cycle as the final write takes effect; further bits SHALL be ignored while full.
REQ-007 Any change of video_bank_sel, detected against a registered copy, SHALL clear wr_addr, bit count, and video_bank_full on the next cycle.
REQ-008 write_video=0 SHALL clear the bit count, discarding any partial byte; wr_addr SHALL be held.
REQ-009 Read side SHALL read from bank ~video_bank_sel only; rd_cnt counts 0..FRAME_PIX-1; byte address = rd_cnt>>3; bit index = 7 - rd_cnt[2:0].
REQ-010 pixel and pixel_valid SHALL appear exactly 2 cycles after the sampled pix_en (RAM read, then bit select); pixel_valid follows pix_en delayed 2 cycles.
REQ-011 pix_en with rd_cnt = FRAME_PIX SHALL saturate the counter and return pixel=0 with pixel_valid=1.
REQ-012 frame_sync SHALL clear rd_cnt to 0; frame_sync together with pix_en: sync wins and that pix_en is dropped (pixel_valid=0 two cycles later).
REQ-013 Each frame_sync SHALL increment rep_cnt; when rep_cnt reaches REPEAT-1 and frame_sync arrives, rep_cnt SHALL clear and frame_done SHALL pulse high the following cycle for exactly 1 cycle.
REQ-014 Write and read to the same RAM location in the same cycle cannot occur (opposite banks); no bypass logic SHALL exist.

Reset
REQ-015 Asynchronous reset SHALL force: video_bank_full=0, pixel=0, pixel_valid=0, frame_done=0, wr_addr=0, bit count=0, rd_cnt=0, rep_cnt=0, registered bank_sel copy=0; RAM contents undefined.
REQ-016 Reset mid-byte or mid-frame SHALL discard partial data; first pixel after release reads address 0.

Structure
REQ-017 FRAME_W, FRAME_H, REPEAT defaults, FRAME_PIX, FRAME_BYTES, and address widths SHALL live in shared package video_pkg.
REQ-018 Storage SHALL be sub-module video_dpram: simple dual-port, 2*FRAME_BYTES x 8, one write port, one registered read port, inferable as block RAM.

Verification
REQ-019 Write 2400 bytes 0xA5 to bank 0 with write_video=1 -> video_bank_full rises after the 19200th strobe; bytes 2401+ are not written.
REQ-020 Toggle video_bank_sel to 1, then issue 160*120 pix_en pulses -> pixel sequence 1,0,1,0,0,1,0,1 repeats, each 2 cycles after pix_en.
REQ-021 Toggle bank_sel mid-frame after 100 bytes -> full=0, next byte written to address {new bank, 0}.
REQ-022 REPEAT=2: four frame_sync pulses -> frame_done pulses twice, one cycle after sync #2 and sync #4.
REQ-023 frame_sync coincident with pix_en -> no pixel_valid for that request; next pix_en returns pixel 0 of the frame.
REQ-024 Assert reset after 5 MISO bits and 300 pixels -> all outputs 0 at once; after release, next 8 bits form byte 0.

Source files
------------

// File: rtl/video_pkg.sv
// Shared frame geometry for the video frame buffer: default dimensions,
// derived sizes and the helpers used to size counters and RAM addresses.
package video_pkg;

  localparam int FRAME_W_DEF = 160;
  localparam int FRAME_H_DEF = 120;
  localparam int REPEAT_DEF  = 2;

  // Bits needed to address n entries (at least one bit).
  function automatic int byte_addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bits needed to hold every value 0..n inclusive.
  function automatic int count_w(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int FRAME_PIX   = FRAME_W_DEF * FRAME_H_DEF;
  localparam int FRAME_BYTES = FRAME_PIX / 8;
  localparam int BYTE_AW     = byte_addr_w(FRAME_BYTES);
  localparam int RAM_AW      = BYTE_AW + 1;

endpackage

// File: rtl/video_dpram.sv
// Simple dual-port byte RAM: one write port, one registered read port.
// The bank bit is the address MSB, so each bank owns a power-of-two window.
module video_dpram
  import video_pkg::*;
#(
  parameter int AW = RAM_AW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/video_frame_buffer.sv
// Double-banked monochrome frame buffer: SPI bytes fill one bank while the
// display scans the other bank pixel by pixel, REPEAT refreshes per frame.
module video_frame_buffer
  import video_pkg::*;
#(
  parameter int FRAME_W = FRAME_W_DEF,
  parameter int FRAME_H = FRAME_H_DEF,
  parameter int REPEAT  = REPEAT_DEF
) (
  input  logic CLK_50,
  input  logic reset,
  input  logic SPI_clock_enable,
  input  logic MISO,
  input  logic write_video,
  input  logic video_bank_sel,
  output logic video_bank_full,
  input  logic pix_en,
  input  logic frame_sync,
  output logic pixel,
  output logic pixel_valid,
  output logic frame_done
);

  localparam int N_PIX   = FRAME_W * FRAME_H;
  localparam int N_BYTES = N_PIX / 8;
  localparam int A_W     = byte_addr_w(N_BYTES);
  localparam int WC_W    = count_w(N_BYTES);
  localparam int RC_W    = count_w(N_PIX);
  localparam int REP_W   = (REPEAT > 1) ? $clog2(REPEAT) : 1;

  localparam logic [WC_W-1:0]  LAST_BYTE = WC_W'(N_BYTES - 1);
  localparam logic [RC_W-1:0]  PIX_END   = RC_W'(N_PIX);
  localparam logic [REP_W-1:0] REP_LAST  = REP_W'(REPEAT - 1);

  // Write side
  logic            bank_q;
  logic [WC_W-1:0] wr_addr;
  logic [2:0]      bit_cnt;
  logic [6:0]      shift;
  logic            bank_change;
  logic            bit_take;
  logic            byte_done;

  assign bank_change = video_bank_sel ^ bank_q;
  assign bit_take    = SPI_clock_enable & write_video & ~video_bank_full & ~bank_change;
  assign byte_done   = bit_take & (bit_cnt == 3'd7);

  always_ff @(posedge CLK_50 or posedge reset) begin
    if (reset) begin
      bank_q          <= 1'b0;
      wr_addr         <= '0;
      bit_cnt         <= '0;
      shift           <= '0;
      video_bank_full <= 1'b0;
    end else begin
      bank_q <= video_bank_sel;
      if (bank_change) begin
        wr_addr         <= '0;
        bit_cnt         <= '0;
        video_bank_full <= 1'b0;
      end else if (!write_video) begin
        bit_cnt <= '0;
      end else if (bit_take) begin
        shift   <= {shift[5:0], MISO};
        bit_cnt <= bit_cnt + 3'd1;
        if (byte_done) begin
          wr_addr <= wr_addr + WC_W'(1);
          if (wr_addr == LAST_BYTE) video_bank_full <= 1'b1;
        end
      end
    end
  end

  // Read side. pix_en is a one-cycle request with no backpressure; the
  // answer appears two cycles later, qualified by pixel_valid.
  logic [RC_W-1:0]  rd_cnt;
  logic [REP_W-1:0] rep_cnt;
  logic             rd_take;
  logic             s1_valid;
  logic             s1_blank;
  logic [2:0]       s1_bit;
  logic [7:0]       rd_byte;

  assign rd_take = pix_en & ~frame_sync;

  always_ff @(posedge CLK_50 or posedge reset) begin
    if (reset) begin
      rd_cnt      <= '0;
      rep_cnt     <= '0;
      s1_valid    <= 1'b0;
      s1_blank    <= 1'b0;
      s1_bit      <= '0;
      pixel       <= 1'b0;
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      s1_valid    <= rd_take;
      pixel_valid <= s1_valid;
      pixel       <= s1_valid & ~s1_blank & rd_byte[s1_bit];
      if (frame_sync) begin
        rd_cnt <= '0;
        if (rep_cnt == REP_LAST) begin
          rep_cnt    <= '0;
          frame_done <= 1'b1;
        end else begin
          rep_cnt <= rep_cnt + REP_W'(1);
        end
      end else if (pix_en) begin
        s1_blank <= (rd_cnt == PIX_END);
        s1_bit   <= ~rd_cnt[2:0];
        if (rd_cnt != PIX_END) rd_cnt <= rd_cnt + RC_W'(1);
      end
    end
  end

  video_dpram #(
    .AW(A_W + 1)
  ) u_ram (
    .clk   (CLK_50),
    .we    (byte_done),
    .waddr ({video_bank_sel, wr_addr[A_W-1:0]}),
    .wdata ({shift, MISO}),
    .re    (rd_take),
    .raddr ({~video_bank_sel, A_W'(rd_cnt >> 3)}),
    .rdata (rd_byte)
  );

endmodule

// File: tb/tb_video_frame_buffer.sv
// Randomised bench for video_frame_buffer: a frame-level reference model
// feeds an expected-pixel queue that a negedge monitor drains.
`timescale 1ns/1ps
module tb_video_frame_buffer;
  import video_pkg::*;

  localparam int PIX   = FRAME_PIX;
  localparam int BYTES = FRAME_BYTES;
  localparam int REP   = REPEAT_DEF;

  logic clk = 1'b0;
  logic rst, spi_en, miso, write_video, bank_sel, pix_en, frame_sync;
  logic bank_full, pixel, pixel_valid, frame_done;

  always #5 clk = ~clk;

  video_frame_buffer dut (
    .CLK_50          (clk),
    .reset           (rst),
    .SPI_clock_enable(spi_en),
    .MISO            (miso),
    .write_video     (write_video),
    .video_bank_sel  (bank_sel),
    .video_bank_full (bank_full),
    .pix_en          (pix_en),
    .frame_sync      (frame_sync),
    .pixel           (pixel),
    .pixel_valid     (pixel_valid),
    .frame_done      (frame_done)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: bank contents plus write/read progress
  logic [7:0] ref_mem [0:1][0:BYTES-1];
  logic [7:0] m_acc;
  int         m_addr, m_cnt, m_rd, m_rep;
  bit         m_full;

  logic [0:0] exp_q[$];
  int         exp_cyc_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: every pixel_valid must match the oldest expectation, on time
  always @(negedge clk) begin
    if (!rst) begin
      if (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin : overdue
        int ec;
        ec = exp_cyc_q.pop_front();
        void'(exp_q.pop_front());
        check("pixel_missing", cyc, ec);
      end
      if (pixel_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_pixel_valid", pixel_valid, 0);
        end else begin : pop
          logic [0:0] e;
          int ec;
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          check("pixel", pixel, e);
          check("pixel_latency", cyc, ec);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_acc = '0; m_addr = 0; m_cnt = 0; m_rd = 0; m_rep = 0; m_full = 0;
  endtask

  task automatic write_bit(input logic b);
    if ($urandom_range(0, 7) == 0) tick();
    spi_en = 1'b1; miso = b; write_video = 1'b1;
    tick();
    spi_en = 1'b0;
    if (!m_full) begin
      m_acc = {m_acc[6:0], b};
      m_cnt++;
      if (m_cnt == 8) begin
        ref_mem[bank_sel][m_addr] = m_acc;
        m_addr++;
        m_cnt = 0;
        if (m_addr == BYTES) m_full = 1;
      end
    end
    check("bank_full", bank_full, m_full);
  endtask

  task automatic write_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
  endtask

  task automatic discard_partial();
    write_video = 1'b0; spi_en = 1'b1; miso = 1'($urandom_range(0, 1));
    tick();
    spi_en = 1'b0; write_video = 1'b1;
    m_cnt = 0;
  endtask

  task automatic set_bank(input logic s);
    bank_sel = s;
    tick();
    m_addr = 0; m_cnt = 0; m_full = 0;
    check("full_after_bank_switch", bank_full, m_full);
  endtask

  task automatic read_pix(input int n, input bit gaps);
    int rb;
    logic [7:0] byte_v;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) tick();
      rb = bank_sel ? 0 : 1;
      pix_en = 1'b1;
      if (m_rd < PIX) begin
        byte_v = ref_mem[rb][m_rd / 8];
        exp_q.push_back(byte_v[7 - (m_rd % 8)]);
        m_rd++;
      end else begin
        exp_q.push_back(1'b0);
      end
      exp_cyc_q.push_back(cyc + 2);
      tick();
      pix_en = 1'b0;
    end
  endtask

  task automatic do_sync(input bit with_pix);
    bit exp_done;
    frame_sync = 1'b1; pix_en = with_pix;
    tick();
    frame_sync = 1'b0; pix_en = 1'b0;
    exp_done = (m_rep == REP - 1);
    m_rep = exp_done ? 0 : m_rep + 1;
    m_rd = 0;
    check("frame_done_pulse", frame_done, exp_done);
    tick();
    check("frame_done_single", frame_done, 0);
  endtask

  initial begin
    logic [7:0] d;
    rst = 1'b1; spi_en = 1'b0; miso = 1'b0; write_video = 1'b0;
    bank_sel = 1'b0; pix_en = 1'b0; frame_sync = 1'b0;
    model_reset();
    repeat (3) tick();
    check("reset_bank_full", bank_full, 0);
    check("reset_pixel", pixel, 0);
    check("reset_pixel_valid", pixel_valid, 0);
    check("reset_frame_done", frame_done, 0);
    rst = 1'b0;
    tick();

    // Fill bank 0 with 0xA5 after a discarded partial byte; overflow ignored
    write_video = 1'b1;
    for (int i = 0; i < 5; i++) write_bit(1'($urandom_range(0, 1)));
    discard_partial();
    for (int i = 0; i < BYTES + 2; i++) write_byte(8'hA5);

    // Display bank 0 in full, then two reads past the end of the frame
    set_bank(1'b1);
    do_sync(1'b0);
    read_pix(PIX, 1'b1);
    read_pix(2, 1'b0);

    // Bank switch mid-frame restarts the write address at zero
    for (int i = 0; i < 100; i++) write_byte(8'($urandom_range(0, 255)));
    for (int i = 0; i < 3; i++) write_bit(1'($urandom_range(0, 1)));
    set_bank(1'b0);
    for (int i = 0; i < 3; i++) write_byte(8'($urandom_range(0, 255)));
    do_sync(1'b0);
    read_pix(800, 1'b1);
    set_bank(1'b1);
    do_sync(1'b0);
    read_pix(40, 1'b1);

    // Sync colliding with a pixel request drops the request
    do_sync(1'b1);
    read_pix(8, 1'b0);

    // Four syncs: frame_done after the second and fourth
    repeat (4) do_sync(1'b0);

    // Reset mid-byte and mid-frame
    for (int i = 0; i < 5; i++) write_bit(1'($urandom_range(0, 1)));
    read_pix(300, 1'b0);
    #1 rst = 1'b1;
    #1;
    check("async_reset_pixel_valid", pixel_valid, 0);
    check("async_reset_pixel", pixel, 0);
    check("async_reset_frame_done", frame_done, 0);
    check("async_reset_bank_full", bank_full, 0);
    exp_q.delete();
    exp_cyc_q.delete();
    model_reset();
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();
    d = 8'($urandom_range(0, 255));
    write_byte(d);
    set_bank(1'b0);
    read_pix(16, 1'b0);

    repeat (4) tick();
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #950000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
